// File: rtl/bp_cce_mem_cmd_serializer.sv
// rtl/bp_cce_mem_cmd_serializer.sv - serializes a CCE memory command (header + block) onto a beat-wide link
//
// Purpose: accepts one memory command (header, block payload, write flag) on a
// ready/valid port. It emits the header as one beat and then, for writes only,
// the payload as beats_lp beats, LSB beat first. The link side uses valid/yumi
// flow control.
//
// Ports:
//   clk_i            - clock, all state updates on the rising edge
//   reset_n_i        - synchronous active-low reset
//   mem_cmd_header_i - command header (hdr_width_p)
//   mem_cmd_data_i   - command block payload (block_width_p)
//   mem_cmd_wr_i     - command carries payload
//   mem_cmd_v_i      - command valid
//   mem_cmd_ready_o  - block can accept a command (depends on state only)
//   link_data_o      - outgoing beat (beat_width_p)
//   link_last_o      - final beat of the current message
//   link_v_o         - beat valid
//   link_yumi_i      - consumer takes the current beat
module bp_cce_mem_cmd_serializer #(
  parameter int hdr_width_p   = 64,
  parameter int block_width_p = 512,
  parameter int beat_width_p  = 64
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic [hdr_width_p-1:0]   mem_cmd_header_i,
  input  logic [block_width_p-1:0] mem_cmd_data_i,
  input  logic                     mem_cmd_wr_i,
  input  logic                     mem_cmd_v_i,
  output logic                     mem_cmd_ready_o,
  output logic [beat_width_p-1:0]  link_data_o,
  output logic                     link_last_o,
  output logic                     link_v_o,
  input  logic                     link_yumi_i
);

  localparam int beats_lp     = block_width_p / beat_width_p;
  localparam int cnt_width_lp = (beats_lp > 1) ? $clog2(beats_lp) : 1;
  localparam logic [cnt_width_lp-1:0] last_cnt_lp = cnt_width_lp'(beats_lp - 1);

  typedef enum logic [1:0] {
    e_ready = 2'd0,
    e_hdr   = 2'd1,
    e_data  = 2'd2
  } state_e;

  state_e                    r_state, w_state_n;
  logic [cnt_width_lp-1:0]   r_cnt, w_cnt_n;
  logic [hdr_width_p-1:0]    r_hdr;
  logic [block_width_p-1:0]  r_data;
  logic                      r_wr;

  logic                      w_ready;
  logic                      w_v;
  logic                      w_last;
  logic [beat_width_p-1:0]   w_beat;
  logic [beat_width_p-1:0]   w_hdr_ext;
  logic [beat_width_p-1:0]   w_data_beat;
  logic                      w_cnt_last;
  logic                      w_accept;

  assign w_cnt_last  = (r_cnt == last_cnt_lp);
  assign w_data_beat = r_data[int'(r_cnt)*beat_width_p +: beat_width_p];

  always_comb begin
    w_hdr_ext                  = '0;
    w_hdr_ext[hdr_width_p-1:0] = r_hdr;
  end

  // The state register is only meaningful after reset has been sampled, so the
  // handshake outputs are held low for as long as reset is asserted.
  assign mem_cmd_ready_o = w_ready & reset_n_i;
  assign link_v_o        = w_v & reset_n_i;
  assign link_last_o     = w_last & reset_n_i;
  assign link_data_o     = w_beat;

  assign w_accept = mem_cmd_ready_o & mem_cmd_v_i;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_state <= e_ready;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
    end
  end

  // Command copy is captured only on acceptance and then held until the
  // message has fully drained; it needs no reset.
  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_hdr  <= mem_cmd_header_i;
      r_data <= mem_cmd_data_i;
      r_wr   <= mem_cmd_wr_i;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_ready   = 1'b0;
    w_v       = 1'b0;
    w_last    = 1'b0;
    w_beat    = '0;
    case (r_state)
      e_ready: begin
        w_ready = 1'b1;
        if (mem_cmd_v_i) begin
          w_state_n = e_hdr;
        end
      end
      e_hdr: begin
        w_v    = 1'b1;
        w_beat = w_hdr_ext;
        w_last = ~r_wr;
        if (link_yumi_i) begin
          if (r_wr) begin
            w_state_n = e_data;
            w_cnt_n   = '0;
          end else begin
            w_state_n = e_ready;
          end
        end
      end
      e_data: begin
        w_v    = 1'b1;
        w_beat = w_data_beat;
        w_last = w_cnt_last;
        if (link_yumi_i) begin
          if (w_cnt_last) begin
            w_cnt_n   = '0;
            w_state_n = e_ready;
          end else begin
            w_cnt_n = r_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_n = e_ready;
        w_cnt_n   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_bp_cce_mem_cmd_serializer.sv
// tb/tb_bp_cce_mem_cmd_serializer.sv - directed self-checking bench for bp_cce_mem_cmd_serializer
module tb_bp_cce_mem_cmd_serializer;

  logic         clk;
  logic         reset_n;
  logic [63:0]  hdr;
  logic [511:0] data;
  logic         wr;
  logic         v;
  logic         ready;
  logic [63:0]  link_data;
  logic         link_last;
  logic         link_v;
  logic         yumi;

  int n_pass  = 0;
  int n_total = 0;

  logic [511:0] blk_inc;
  logic [511:0] blk_alt;

  bp_cce_mem_cmd_serializer dut (
    .clk_i            (clk),
    .reset_n_i        (reset_n),
    .mem_cmd_header_i (hdr),
    .mem_cmd_data_i   (data),
    .mem_cmd_wr_i     (wr),
    .mem_cmd_v_i      (v),
    .mem_cmd_ready_o  (ready),
    .link_data_o      (link_data),
    .link_last_o      (link_last),
    .link_v_o         (link_v),
    .link_yumi_i      (yumi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_beat(input string tag, input logic [63:0] d, input logic l);
    check({tag, ".v"}, {63'd0, link_v}, 64'd1);
    check({tag, ".data"}, link_data, d);
    check({tag, ".last"}, {63'd0, link_last}, {63'd0, l});
    check({tag, ".ready"}, {63'd0, ready}, 64'd0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".ready"}, {63'd0, ready}, 64'd1);
    check({tag, ".v"}, {63'd0, link_v}, 64'd0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      blk_inc[i*64 +: 64] = 64'(i);
      blk_alt[i*64 +: 64] = 64'hA0 + 64'(i);
    end

    reset_n = 1'b0; hdr = '0; data = '0; wr = 1'b0; v = 1'b0; yumi = 1'b0;
    tick();
    tick();
    check("rst.ready", {63'd0, ready}, 64'd0);
    check("rst.v", {63'd0, link_v}, 64'd0);
    check("rst.last", {63'd0, link_last}, 64'd0);
    reset_n = 1'b1;
    #1;
    check_idle("post_rst");

    // stray yumi while idle must not move the block
    yumi = 1'b1;
    tick();
    check_idle("stray_yumi");

    // single-beat read
    hdr = 64'h1234; wr = 1'b0; v = 1'b1; yumi = 1'b1;
    tick();
    check_beat("rd.hdr", 64'h1234, 1'b1);
    v = 1'b0;
    tick();
    check_idle("rd.done");

    // full write, yumi held high
    hdr = 64'hABCD; data = blk_inc; wr = 1'b1; v = 1'b1;
    tick();
    check_beat("wr.hdr", 64'hABCD, 1'b0);
    v = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_beat($sformatf("wr.beat%0d", i), 64'(i), i == 7);
    end
    tick();
    check_idle("wr.done");

    // write with a 5-cycle stall on beat 3
    hdr = 64'h0BAD; data = blk_inc; wr = 1'b1; v = 1'b1;
    tick();
    check_beat("bp.hdr", 64'h0BAD, 1'b0);
    v = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check_beat("bp.beat3", 64'd3, 1'b0);
    yumi = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check_beat($sformatf("bp.stall%0d", k), 64'd3, 1'b0);
    end
    yumi = 1'b1;
    for (int i = 4; i < 8; i++) begin
      tick();
      check_beat($sformatf("bp.beat%0d", i), 64'(i), i == 7);
    end
    tick();
    check_idle("bp.done");

    // new command offered while busy must wait and not corrupt the message
    hdr = 64'hC0DE; data = blk_inc; wr = 1'b1; v = 1'b1;
    tick();
    check_beat("chg.hdr", 64'hC0DE, 1'b0);
    v = 1'b0;
    tick();
    check_beat("chg.beat0", 64'd0, 1'b0);
    hdr = 64'h5555; data = blk_alt; wr = 1'b0; v = 1'b1;
    for (int i = 1; i < 8; i++) begin
      tick();
      check_beat($sformatf("chg.beat%0d", i), 64'(i), i == 7);
    end
    tick();
    check_idle("chg.ready");
    tick();
    check_beat("chg.new_hdr", 64'h5555, 1'b1);
    v = 1'b0;
    tick();
    check_idle("chg.done");

    // reset in the middle of a write
    hdr = 64'hDEAD; data = blk_inc; wr = 1'b1; v = 1'b1;
    tick();
    check_beat("mrst.hdr", 64'hDEAD, 1'b0);
    v = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check_beat("mrst.beat4", 64'd4, 1'b0);
    reset_n = 1'b0;
    tick();
    check("mrst.v", {63'd0, link_v}, 64'd0);
    check("mrst.ready", {63'd0, ready}, 64'd0);
    check("mrst.last", {63'd0, link_last}, 64'd0);
    reset_n = 1'b1;
    #1;
    check_idle("mrst.release");
    hdr = 64'h77; wr = 1'b0; v = 1'b1;
    tick();
    check_beat("mrst.rd_hdr", 64'h77, 1'b1);
    v = 1'b0;
    tick();
    check_idle("mrst.rd_done");

    // back-to-back reads: header and ready cycles alternate
    hdr = 64'h99; wr = 1'b0; v = 1'b1; yumi = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      check_beat($sformatf("b2b.hdr%0d", k), 64'h99, 1'b1);
      tick();
      check_idle($sformatf("b2b.idle%0d", k));
    end
    v = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bp_cce_mem_cmd_serializer.md
BP_CCE_MEM_CMD_SERIALIZER -- requirements
Module: bp_cce_mem_cmd_serializer

Interface
- REQ-001 SHALL have parameter hdr_width_p, default 64: memory command header width in bits; must be <= beat_width_p.
- REQ-002 SHALL have parameter block_width_p, default 512: cache block payload width in bits.
- REQ-003 SHALL have parameter beat_width_p, default 64: link beat width; block_width_p must be an integer multiple of it.
- REQ-004 SHALL derive localparam beats_lp = block_width_p/beat_width_p (default 8) and cnt_width_lp = max(1, clog2(beats_lp)).
- REQ-005 SHALL have port clk_i, input, 1: single clock; all state updates on its rising edge.
- REQ-006 SHALL have port reset_n_i, input, 1: reset, synchronous and active-low.
- REQ-007 SHALL have port mem_cmd_header_i, input, hdr_width_p: header of the command emitted by the CCE.
- REQ-008 SHALL have port mem_cmd_data_i, input, block_width_p: block payload of the same command.
- REQ-009 SHALL have port mem_cmd_wr_i, input, 1: command carries payload (writeback or uncached write).
- REQ-010 SHALL have port mem_cmd_v_i, input, 1: command valid.
- REQ-011 SHALL have port mem_cmd_ready_o, output, 1: ready->valid acceptance; the transfer occurs when ready_o & v_i.
- REQ-012 SHALL have port link_data_o, output, beat_width_p: outgoing beat.
- REQ-013 SHALL have port link_last_o, output, 1: final beat of the current message.
- REQ-014 SHALL have port link_v_o, output, 1: beat valid.
- REQ-015 SHALL have port link_yumi_i, input, 1: consumer takes the beat; legal only when link_v_o=1.

Function
- REQ-016 SHALL implement a state machine with states e_ready, e_hdr, e_data.
- REQ-017 e_ready: mem_cmd_ready_o=1 and link_v_o=0; on mem_cmd_v_i=1, SHALL register header, data and wr, and go to e_hdr.
- REQ-018 mem_cmd_ready_o SHALL be 0 in e_hdr and e_data; it SHALL depend only on state, not on link_yumi_i or mem_cmd_v_i.
- REQ-019 e_hdr: link_v_o=1; link_data_o = registered header zero-extended to beat_width_p; link_last_o = ~wr.
- REQ-020 On yumi in e_hdr: SHALL go to e_data with beat counter cleared to 0 if wr=1, else to e_ready.
- REQ-021 e_data: link_v_o=1; link_data_o = registered data bits [cnt*beat_width_p +: beat_width_p] (beat 0 = LSBs); link_last_o = (cnt == beats_lp-1).
- REQ-022 On yumi in e_data: SHALL increment cnt if not last; on the last beat SHALL clear cnt and return to e_ready.
- REQ-023 Outputs SHALL stay stable while link_v_o=1 and yumi=0, with no limit on stall length.
- REQ-024 Latency: a command accepted in cycle t SHALL present its header beat at cycle t+1.
- REQ-025 mem_cmd_ready_o SHALL rise in the cycle after the final handshake, with no same-cycle bypass.
- REQ-026 Minimum occupancy SHALL be 2 cycles for a read and beats_lp+2 cycles for a write.
- REQ-027 mem_cmd_* inputs SHALL be ignored outside e_ready; the registered copy SHALL NOT change until the return to e_ready.
- REQ-028 link_yumi_i asserted with link_v_o=0 is illegal; the block SHALL ignore it and leave state unchanged.
- REQ-029 When beats_lp=1, the single data beat SHALL carry link_last_o=1 and the counter SHALL never increment.

Reset
- REQ-030 While reset_n_i=0 at a clock edge: state SHALL become e_ready, cnt 0, link_v_o=0, link_last_o=0, mem_cmd_ready_o=0.
- REQ-031 mem_cmd_ready_o SHALL be 1 in the first cycle after reset_n_i returns high.
- REQ-032 Reset mid-message SHALL discard the in-flight message entirely; no partial beats SHALL appear after reset deasserts.
- REQ-033 The data and header registers SHALL need no reset; state and cnt SHALL need reset.

Verification
- REQ-034 Read: header 0x0000_0000_0000_1234, wr=0, yumi held 1 -> one beat 0x1234 with last=1 at t+1; ready_o=1 at t+2.
- REQ-035 Write: data = beat i holding value i (i = 0..7), wr=1 -> header beat (last=0), then beats 0..7 in order, last=1 only on beat 7; ready_o=1 after 10 cycles.
- REQ-036 Backpressure: yumi=0 for 5 cycles during data beat 3 -> link_data_o and last stay constant, cnt stays 3, ready_o stays 0.
- REQ-037 Input change while busy: alter mem_cmd_data_i with v_i=1 during e_data -> emitted beats match the originally accepted data; the new command is accepted only after return to e_ready.
- REQ-038 Reset at data beat 4 -> link_v_o=0 next cycle, ready_o=1 after deassertion, and the next read emits only its header.
- REQ-039 Back-to-back reads with v_i held 1 and yumi held 1 -> one accept every 2 cycles; header beats alternate with ready cycles.
